// File: rtl/rcpu_step_ctrl.sv
// Step-pulse controller: conditions the step button and mode switches, then issues cpu_step enables.
// Optional macro RCPU_STEP_HALT_EN adds halt_req input and halted status output.
module rcpu_step_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int RUN_DIV   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [1:0] mode,
`ifdef RCPU_STEP_HALT_EN
    input  logic       halt_req,
    output logic       halted,
`endif
    output logic       cpu_step,
    output logic       busy,
    output logic [7:0] step_count
);

    localparam int DB_W  = $clog2(DB_CYCLES);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    localparam logic [1:0] M_HALT   = 2'd0;
    localparam logic [1:0] M_SINGLE = 2'd1;
    localparam logic [1:0] M_RUN    = 2'd2;
    localparam logic [1:0] M_BURST  = 2'd3;

    logic             btn_s1, btn_s2;
    logic [1:0]       mode_s1, mode_s2;
    logic [DB_W-1:0]  db_cnt;
    logic             btn_stable;
    logic             db_hit;
    logic             press;

    logic [1:0]       state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [7:0]       rem_reg, rem_next;
    logic             step_next;
    logic             div_hit;
    logic             cpu_step_reg;
    logic             busy_reg;
    logic [7:0]       count_reg;
    logic             halt_in;
    logic             halt_blk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            mode_s1 <= 2'b00;
            mode_s2 <= 2'b00;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
        end
    end

    // press fires in the cycle the debouncer accepts a new high level
    assign db_hit = (btn_s2 != btn_stable) && (db_cnt == DB_W'(DB_CYCLES - 1));
    assign press  = db_hit && btn_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt     <= '0;
            btn_stable <= 1'b0;
        end else if (btn_s2 != btn_stable) begin
            if (db_hit) begin
                btn_stable <= btn_s2;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

`ifdef RCPU_STEP_HALT_EN
    logic       halted_reg;
    logic [1:0] mode_d;

    assign halt_in  = halt_req;
    assign halt_blk = halted_reg;
    assign halted   = halted_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_reg <= 1'b0;
            mode_d     <= 2'b00;
        end else begin
            mode_d <= mode_s2;
            if ((state_reg != ST_IDLE) && halt_req)
                halted_reg <= 1'b1;
            else if (press || (mode_s2 != mode_d))
                halted_reg <= 1'b0;
        end
    end
`else
    assign halt_in  = 1'b0;
    assign halt_blk = 1'b0;
`endif

    assign div_hit = (div_reg == DIV_W'(RUN_DIV - 1));

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        rem_next   = rem_reg;
        step_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                div_next = '0;
                if (mode_s2 == M_SINGLE && press && !halt_in) begin
                    step_next = 1'b1;
                end else if (mode_s2 == M_BURST && press) begin
                    rem_next   = 8'(BURST_LEN);
                    state_next = ST_BURST;
                end else if (mode_s2 == M_RUN && !halt_blk) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_in || mode_s2 != M_RUN) begin
                    state_next = ST_IDLE;
                end else if (div_hit) begin
                    step_next = 1'b1;
                    div_next  = '0;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            ST_BURST: begin
                // only HALT (or halt_req) can cut a burst short
                if (halt_in || mode_s2 == M_HALT) begin
                    state_next = ST_IDLE;
                end else if (div_hit) begin
                    step_next = 1'b1;
                    div_next  = '0;
                    rem_next  = rem_reg - 8'd1;
                    if (rem_reg == 8'd1)
                        state_next = ST_IDLE;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            div_reg      <= '0;
            rem_reg      <= 8'd0;
            cpu_step_reg <= 1'b0;
            busy_reg     <= 1'b0;
            count_reg    <= 8'd0;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            rem_reg      <= rem_next;
            cpu_step_reg <= step_next;
            busy_reg     <= (state_next != ST_IDLE);
            count_reg    <= count_reg + {7'd0, cpu_step_reg};
        end
    end

    assign cpu_step   = cpu_step_reg;
    assign busy       = busy_reg;
    assign step_count = count_reg;

endmodule

// File: tb/tb_rcpu_step_ctrl.sv
// Directed bench for rcpu_step_ctrl with default parameters (DB_CYCLES=16, RUN_DIV=4, BURST_LEN=4).
// Define RCPU_STEP_HALT_EN to also exercise the halt_req/halted feature.
module tb_rcpu_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_raw = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       cpu_step;
    logic       busy;
    logic [7:0] step_count;
`ifdef RCPU_STEP_HALT_EN
    logic       halt_req = 1'b0;
    logic       halted;
`endif

    int checks = 0;
    int failures = 0;

    rcpu_step_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .mode       (mode),
`ifdef RCPU_STEP_HALT_EN
        .halt_req   (halt_req),
        .halted     (halted),
`endif
        .cpu_step   (cpu_step),
        .busy       (busy),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn_raw = ~btn_raw;
            tick();
            checks += 3;
            if (cpu_step !== 1'b0) begin failures++; $display("FAIL reset_cpu_step cyc=%0d got=%b exp=0", i, cpu_step); end
            if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy); end
            if (step_count !== 8'd0) begin failures++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, step_count); end
`ifdef RCPU_STEP_HALT_EN
            checks++;
            if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted cyc=%0d got=%b exp=0", i, halted); end
`endif
        end
        btn_raw = 1'b0;
        rst = 1'b1;
        repeat (25) tick();
        $display("reset: done, step_count=%0d", step_count);
    endtask

    task automatic test_single();
        logic [9:0] bounce;
        int first_at;
        int pulses;
        bounce = 10'b0100101101;
        mode = 2'd1;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            btn_raw = bounce[i];
            tick();
        end
        btn_raw = 1'b1;
        first_at = 0;
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (cpu_step === 1'b1) begin
                pulses++;
                if (first_at == 0) first_at = n;
            end
        end
        checks += 3;
        if (first_at != 18) begin failures++; $display("FAIL single_latency got=%0d exp=18", first_at); end
        if (pulses != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
        if (step_count !== 8'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", step_count); end
        $display("single: latency=%0d pulses=%0d step_count=%0d", first_at, pulses, step_count);
        btn_raw = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_burst();
        int ptimes[4];
        int exp_t[4];
        int pulses;
        exp_t = '{22, 26, 30, 34};
        ptimes = '{0, 0, 0, 0};
        pulses = 0;
        mode = 2'd3;
        repeat (4) tick();
        btn_raw = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (cpu_step === 1'b1) begin
                if (pulses < 4) ptimes[pulses] = n;
                pulses++;
            end
            if (n == 18 || n == 33) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL burst_busy_hi n=%0d got=%b exp=1", n, busy); end
            end
            if (n == 34) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL burst_busy_lo n=%0d got=%b exp=0", n, busy); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ptimes[k] != exp_t[k]) begin failures++; $display("FAIL burst_pulse_time k=%0d got=%0d exp=%0d", k, ptimes[k], exp_t[k]); end
        end
        checks += 2;
        if (pulses != 4) begin failures++; $display("FAIL burst_pulses got=%0d exp=4", pulses); end
        if (step_count !== 8'd5) begin failures++; $display("FAIL burst_count got=%0d exp=5", step_count); end
        $display("burst: pulses=%0d at %0d,%0d,%0d,%0d step_count=%0d", pulses, ptimes[0], ptimes[1], ptimes[2], ptimes[3], step_count);
        btn_raw = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_run();
        int pulses;
        int tail;
        pulses = 0;
        tail = 0;
        mode = 2'd2;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (cpu_step === 1'b1) pulses++;
            if (n == 3) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL run_busy_entry got=%b exp=1", busy); end
            end
        end
        mode = 2'd0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (cpu_step === 1'b1) tail++;
            if (n == 2) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL run_busy_hold got=%b exp=1", busy); end
            end
            if (n == 3) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL run_busy_exit got=%b exp=0", busy); end
            end
        end
        checks += 3;
        if (pulses != 24) begin failures++; $display("FAIL run_pulses got=%0d exp=24", pulses); end
        if (tail != 0) begin failures++; $display("FAIL run_tail_pulses got=%0d exp=0", tail); end
        if (step_count !== 8'd29) begin failures++; $display("FAIL run_count got=%0d exp=29", step_count); end
        $display("run: pulses=%0d tail=%0d step_count=%0d", pulses, tail, step_count);
    endtask

    task automatic test_press_dropped();
        int late;
        late = 0;
        mode = 2'd2;
        repeat (10) tick();
        btn_raw = 1'b1;
        repeat (20) tick();
        mode = 2'd3;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n >= 3 && cpu_step === 1'b1) late++;
        end
        checks += 2;
        if (late != 0) begin failures++; $display("FAIL dropped_press_pulses got=%0d exp=0", late); end
        if (busy !== 1'b0) begin failures++; $display("FAIL dropped_press_busy got=%b exp=0", busy); end
        $display("press_dropped: late_pulses=%0d busy=%b", late, busy);
        btn_raw = 1'b0;
        mode = 2'd0;
        repeat (25) tick();
    endtask

`ifdef RCPU_STEP_HALT_EN
    task automatic test_halt();
        int idle_pulses;
        idle_pulses = 0;
        mode = 2'd2;
        repeat (6) tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL halt_busy_before got=%b exp=1", busy); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks += 3;
        if (cpu_step !== 1'b0) begin failures++; $display("FAIL halt_suppress got=%b exp=0", cpu_step); end
        if (busy !== 1'b0) begin failures++; $display("FAIL halt_busy got=%b exp=0", busy); end
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
        for (int n = 0; n < 10; n++) begin
            tick();
            if (cpu_step === 1'b1) idle_pulses++;
        end
        checks += 2;
        if (idle_pulses != 0) begin failures++; $display("FAIL halt_idle_pulses got=%0d exp=0", idle_pulses); end
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag_hold got=%b exp=1", halted); end
        btn_raw = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            tick();
            if (n == 17) begin
                checks++;
                if (halted !== 1'b1) begin failures++; $display("FAIL halt_before_press got=%b exp=1", halted); end
            end
            if (n == 18) begin
                checks++;
                if (halted !== 1'b0) begin failures++; $display("FAIL halt_clear_press got=%b exp=0", halted); end
            end
        end
        $display("halt: idle_pulses=%0d halted=%b", idle_pulses, halted);
        mode = 2'd0;
        btn_raw = 1'b0;
        repeat (30) tick();
    endtask
`endif

    task automatic test_wrap_and_async_reset();
        int pulses;
        int n;
        int waited;
        rst = 1'b0;
        mode = 2'd2;
        btn_raw = 1'b0;
        tick();
        tick();
        checks++;
        if (step_count !== 8'd0) begin failures++; $display("FAIL wrap_start_count got=%0d exp=0", step_count); end
        rst = 1'b1;
        pulses = 0;
        n = 0;
        while (pulses < 260 && n < 1200) begin
            tick();
            n++;
            if (cpu_step === 1'b1) pulses++;
        end
        checks += 2;
        if (pulses != 260) begin failures++; $display("FAIL wrap_timeout pulses=%0d exp=260", pulses); end
        if (n != 1043) begin failures++; $display("FAIL wrap_last_pulse_cycle got=%0d exp=1043", n); end
        tick();
        checks++;
        if (step_count !== 8'd4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", step_count); end
        $display("wrap: pulses=%0d last_at=%0d step_count=%0d", pulses, n, step_count);
        waited = 0;
        while (cpu_step !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        checks += 2;
        if (cpu_step !== 1'b1) begin failures++; $display("FAIL async_pre_pulse got=%b exp=1", cpu_step); end
        if (busy !== 1'b1) begin failures++; $display("FAIL async_pre_busy got=%b exp=1", busy); end
        rst = 1'b0;
        #1;
        checks += 3;
        if (cpu_step !== 1'b0) begin failures++; $display("FAIL async_cpu_step got=%b exp=0", cpu_step); end
        if (busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", busy); end
        if (step_count !== 8'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", step_count); end
        $display("async_reset: cpu_step=%b busy=%b step_count=%0d", cpu_step, busy, step_count);
        mode = 2'd0;
        tick();
        rst = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_run();
        test_press_dropped();
`ifdef RCPU_STEP_HALT_EN
        test_halt();
`endif
        test_wrap_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
